// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide unit.
// One radix-2 step per BUSY cycle (shift-add multiply, restoring divide) on
// operand magnitudes, with sign correction applied when the result is
// registered. Divide-by-zero and signed overflow can bypass the iteration.
module muldiv_unit #(
  parameter int unsigned DWIDTH       = 32,
  parameter bit          FAST_SPECIAL = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              valid_i,
  output logic              ready_o,
  input  logic [2:0]        funct3_i,
  input  logic [DWIDTH-1:0] rs1_i,
  input  logic [DWIDTH-1:0] rs2_i,
  input  logic              kill_i,
  output logic              valid_o,
  input  logic              ready_i,
  output logic [DWIDTH-1:0] res_o
);

  localparam int unsigned PW = 2 * DWIDTH;
  localparam int unsigned CW = $clog2(DWIDTH + 1);
  localparam logic [DWIDTH-1:0] MOST_NEG = {1'b1, {(DWIDTH-1){1'b0}}};
  localparam logic [DWIDTH-1:0] ALL_ONES = {DWIDTH{1'b1}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_next;

  // Registered outputs
  logic              ready_q;
  logic              valid_q;
  logic [DWIDTH-1:0] res_q;

  // Latched operation context
  logic [2:0]        op_q;
  logic [DWIDTH-1:0] opnd_q;       // multiplicand magnitude or divisor magnitude
  logic [PW-1:0]     prod_q;       // {acc/remainder, multiplier/quotient}
  logic [CW-1:0]     cnt_q;
  logic              neg_q;        // product / quotient sign
  logic              rem_neg_q;    // remainder sign (follows dividend)
  logic              special_q;
  logic [DWIDTH-1:0] special_res_q;

  // Request decode
  logic              signed_a_c, signed_b_c;
  logic              a_neg_c, b_neg_c;
  logic [DWIDTH-1:0] a_mag_c, b_mag_c;
  logic              div_zero_c, ovf_c, special_c;
  logic [DWIDTH-1:0] special_res_c;
  logic              accept_c;

  // Iteration step and final result
  logic [DWIDTH:0]   mul_sum_c;
  logic [DWIDTH:0]   rem_sh_c;
  logic [DWIDTH:0]   diff_c;
  logic [PW-1:0]     step_c;
  logic [PW-1:0]     mul_full_c;
  logic [DWIDTH-1:0] quo_c, rem_c;
  logic [DWIDTH-1:0] result_c;

  assign ready_o = ready_q;
  assign valid_o = valid_q;
  assign res_o   = res_q;

  // Operand signedness, magnitudes and special-case detection at the request
  always_comb begin
    signed_a_c    = (funct3_i == 3'b000) || (funct3_i == 3'b001) || (funct3_i == 3'b010) ||
                    (funct3_i == 3'b100) || (funct3_i == 3'b110);
    signed_b_c    = (funct3_i == 3'b000) || (funct3_i == 3'b001) ||
                    (funct3_i == 3'b100) || (funct3_i == 3'b110);
    a_neg_c       = signed_a_c && rs1_i[DWIDTH-1];
    b_neg_c       = signed_b_c && rs2_i[DWIDTH-1];
    a_mag_c       = a_neg_c ? (DWIDTH'(0) - rs1_i) : rs1_i;
    b_mag_c       = b_neg_c ? (DWIDTH'(0) - rs2_i) : rs2_i;
    div_zero_c    = funct3_i[2] && (rs2_i == '0);
    ovf_c         = funct3_i[2] && !funct3_i[0] && (rs1_i == MOST_NEG) && (rs2_i == ALL_ONES);
    special_c     = div_zero_c || ovf_c;
    special_res_c = '0;
    if (div_zero_c) begin
      special_res_c = funct3_i[1] ? rs1_i : ALL_ONES;
    end else if (ovf_c) begin
      special_res_c = funct3_i[1] ? '0 : rs1_i;
    end
    accept_c      = valid_i && (state == IDLE) && !kill_i;
  end

  // One radix-2 step: shift-add multiply or restoring shift-subtract divide
  always_comb begin
    mul_sum_c = {1'b0, prod_q[PW-1:DWIDTH]} + {1'b0, opnd_q};
    rem_sh_c  = {prod_q[PW-1:DWIDTH], prod_q[DWIDTH-1]};
    diff_c    = rem_sh_c - {1'b0, opnd_q};
    if (op_q[2]) begin
      if (diff_c[DWIDTH]) begin
        step_c = {rem_sh_c[DWIDTH-1:0], prod_q[DWIDTH-2:0], 1'b0};
      end else begin
        step_c = {diff_c[DWIDTH-1:0], prod_q[DWIDTH-2:0], 1'b1};
      end
    end else if (prod_q[0]) begin
      step_c = {mul_sum_c, prod_q[DWIDTH-1:1]};
    end else begin
      step_c = {1'b0, prod_q[PW-1:1]};
    end
  end

  // Sign correction and result selection from the final step value
  always_comb begin
    mul_full_c = neg_q ? (PW'(0) - step_c) : step_c;
    quo_c      = step_c[DWIDTH-1:0];
    rem_c      = step_c[PW-1:DWIDTH];
    if (neg_q)     quo_c = DWIDTH'(0) - quo_c;
    if (rem_neg_q) rem_c = DWIDTH'(0) - rem_c;
    case (op_q)
      3'b000:                 result_c = mul_full_c[DWIDTH-1:0];
      3'b001, 3'b010, 3'b011: result_c = mul_full_c[PW-1:DWIDTH];
      3'b100, 3'b101:         result_c = quo_c;
      default:                result_c = rem_c;
    endcase
  end

  // Next-state logic; kill overrides accept and retire
  always_comb begin
    state_next = state;
    if (kill_i) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE: if (valid_i) state_next = (FAST_SPECIAL && special_c) ? DONE : BUSY;
        BUSY: if (cnt_q == CW'(1)) state_next = DONE;
        DONE: if (ready_i) state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  // State register and handshake outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      ready_q <= 1'b1;
      valid_q <= 1'b0;
    end else begin
      state   <= state_next;
      ready_q <= (state_next == IDLE);
      valid_q <= (state_next == DONE);
    end
  end

  // Operand latch on accept, iteration while busy, result capture on entering DONE
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_q          <= '0;
      opnd_q        <= '0;
      prod_q        <= '0;
      cnt_q         <= '0;
      neg_q         <= 1'b0;
      rem_neg_q     <= 1'b0;
      special_q     <= 1'b0;
      special_res_q <= '0;
      res_q         <= '0;
    end else begin
      if (accept_c) begin
        op_q          <= funct3_i;
        opnd_q        <= funct3_i[2] ? b_mag_c : a_mag_c;
        prod_q        <= funct3_i[2] ? {{DWIDTH{1'b0}}, a_mag_c} : {{DWIDTH{1'b0}}, b_mag_c};
        cnt_q         <= CW'(DWIDTH);
        neg_q         <= a_neg_c ^ b_neg_c;
        rem_neg_q     <= a_neg_c;
        special_q     <= special_c;
        special_res_q <= special_res_c;
      end else if (state == BUSY && !kill_i) begin
        prod_q <= step_c;
        cnt_q  <= cnt_q - CW'(1);
      end
      if (state_next == DONE && state != DONE) begin
        if (state == IDLE) begin
          res_q <= special_res_c;
        end else begin
          res_q <= special_q ? special_res_q : result_c;
        end
      end
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed and randomized checks of muldiv_unit against an
// arithmetic reference model (64-bit products, native signed divide).
module tb_muldiv_unit;

  localparam int unsigned W = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic         valid_i;
  logic         ready_o;
  logic [2:0]   funct3_i;
  logic [W-1:0] rs1_i;
  logic [W-1:0] rs2_i;
  logic         kill_i;
  logic         valid_o;
  logic         ready_i;
  logic [W-1:0] res_o;

  int errs   = 0;
  int checks = 0;

  muldiv_unit #(.DWIDTH(W), .FAST_SPECIAL(1'b1)) dut (
    .clk      (clk),
    .reset    (reset),
    .valid_i  (valid_i),
    .ready_o  (ready_o),
    .funct3_i (funct3_i),
    .rs1_i    (rs1_i),
    .rs2_i    (rs2_i),
    .kill_i   (kill_i),
    .valid_o  (valid_o),
    .ready_i  (ready_i),
    .res_o    (res_o)
  );

  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference result straight from the RV32M definitions
  function automatic logic [W-1:0] model(input logic [2:0] f, input logic [W-1:0] a,
                                         input logic [W-1:0] b);
    logic signed [63:0] sa, sb, sp;
    logic        [63:0] ua, ub, up;
    logic signed [31:0] qa, qb, qr;
    sa = $signed({{32{a[31]}}, a});
    sb = $signed({{32{b[31]}}, b});
    ua = {32'h0, a};
    ub = {32'h0, b};
    qa = $signed(a);
    qb = $signed(b);
    case (f)
      3'd0: begin sp = sa * sb; return sp[31:0]; end
      3'd1: begin sp = sa * sb; return sp[63:32]; end
      3'd2: begin sp = sa * $signed(ub); return sp[63:32]; end
      3'd3: begin up = ua * ub; return up[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
        qr = qa / qb; return qr;
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
        qr = qa % qb; return qr;
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic bit is_special(input logic [2:0] f, input logic [W-1:0] a,
                                    input logic [W-1:0] b);
    if (f[2] && b == 0) return 1'b1;
    if ((f == 3'd4 || f == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1'b1;
    return 1'b0;
  endfunction

  // Issue one op, measure latency, optionally stall the consumer, then retire
  task automatic do_op(input logic [2:0] f, input logic [W-1:0] a, input logic [W-1:0] b,
                       input int hold, input bit junk);
    logic [W-1:0] exp_res;
    int           exp_cyc;
    int           cyc;
    logic [W-1:0] first_res;
    exp_res = model(f, a, b);
    exp_cyc = is_special(f, a, b) ? 1 : W + 1;
    chk("ready_before_req", 64'(ready_o), 64'(1));
    valid_i = 1'b1; funct3_i = f; rs1_i = a; rs2_i = b;
    @(posedge clk); #1;
    cyc = 1;
    // Requests presented while busy must be ignored
    if (junk) begin
      valid_i = 1'b1; funct3_i = 3'($urandom); rs1_i = $urandom; rs2_i = $urandom;
    end else begin
      valid_i = 1'b0;
    end
    while (valid_o !== 1'b1 && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
    end
    valid_i = 1'b0;
    chk($sformatf("latency f%0d", f), 64'(cyc), 64'(exp_cyc));
    chk($sformatf("result f%0d %h %h", f, a, b), 64'(res_o), 64'(exp_res));
    chk("ready_low_in_done", 64'(ready_o), 64'(0));
    first_res = res_o;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk("hold_valid", 64'(valid_o), 64'(1));
      chk("hold_res", 64'(res_o), 64'(first_res));
    end
    // Offer a request on the retire edge; it must not be accepted
    ready_i = 1'b1; valid_i = 1'b1; funct3_i = 3'd0; rs1_i = 32'd5; rs2_i = 32'd6;
    @(posedge clk); #1;
    ready_i = 1'b0; valid_i = 1'b0;
    chk("retire_valid_low", 64'(valid_o), 64'(0));
    chk("retire_ready_high", 64'(ready_o), 64'(1));
    @(posedge clk); #1;
    chk("no_accept_on_retire", 64'(ready_o), 64'(1));
  endtask

  function automatic logic [W-1:0] pick_operand();
    case ($urandom_range(0, 7))
      0:       return 32'h0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic [2:0]   rf;
    logic [W-1:0] ra, rb;
    bit           seen;

    reset = 1'b1; valid_i = 1'b0; funct3_i = '0; rs1_i = '0; rs2_i = '0;
    kill_i = 1'b0; ready_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_ready", 64'(ready_o), 64'(1));
    chk("reset_valid", 64'(valid_o), 64'(0));
    chk("reset_res", 64'(res_o), 64'(0));
    reset = 1'b0;
    @(posedge clk); #1;

    // Directed examples
    do_op(3'd0, 32'd7, 32'hFFFF_FFFD, 0, 1'b0);
    do_op(3'd1, 32'h8000_0000, 32'h8000_0000, 0, 1'b1);
    do_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 1'b0);
    do_op(3'd2, 32'hFFFF_FFFF, 32'd2, 0, 1'b0);
    do_op(3'd4, 32'hFFFF_FFF9, 32'd2, 0, 1'b0);
    do_op(3'd6, 32'hFFFF_FFF9, 32'd2, 0, 1'b0);
    do_op(3'd5, 32'd100, 32'd7, 0, 1'b0);
    do_op(3'd5, 32'd5, 32'd0, 0, 1'b1);
    do_op(3'd7, 32'd5, 32'd0, 0, 1'b0);
    do_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 0, 1'b0);
    do_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 0, 1'b0);
    do_op(3'd4, 32'hFFFF_FFF9, 32'd0, 0, 1'b0);
    do_op(3'd6, 32'hFFFF_FFF9, 32'd0, 0, 1'b0);
    do_op(3'd0, 32'd12345, 32'd678, 5, 1'b0);

    // Kill a DIV during cycle 10: back to IDLE in cycle 11, result never shown
    valid_i = 1'b1; funct3_i = 3'd4; rs1_i = 32'd1000; rs2_i = 32'd7;
    @(posedge clk); #1;
    valid_i = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    kill_i = 1'b1;
    @(posedge clk); #1;
    kill_i = 1'b0;
    chk("kill_ready", 64'(ready_o), 64'(1));
    chk("kill_valid", 64'(valid_o), 64'(0));
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (valid_o) seen = 1'b1;
    end
    chk("kill_no_valid", 64'(seen), 64'(0));

    // Reset during cycle 20 of a MUL takes effect without a clock edge
    valid_i = 1'b1; funct3_i = 3'd0; rs1_i = 32'd99; rs2_i = 32'd77;
    @(posedge clk); #1;
    valid_i = 1'b0;
    repeat (19) @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    chk("async_reset_ready", 64'(ready_o), 64'(1));
    chk("async_reset_valid", 64'(valid_o), 64'(0));
    chk("async_reset_res", 64'(res_o), 64'(0));
    @(posedge clk); #1;
    reset = 1'b0;
    do_op(3'd0, 32'd3, 32'd4, 0, 1'b0);

    // Randomized operations with a biased operand mix
    for (int n = 0; n < 48; n++) begin
      rf = 3'($urandom);
      ra = pick_operand();
      rb = pick_operand();
      do_op(rf, ra, rb, int'($urandom_range(0, 2)), 1'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 Parameter DWIDTH, default 32, SHALL set operand and result width (even, >= 8).
REQ-002 Parameter FAST_SPECIAL, default 1, SHALL enable the 1-cycle path for divide-by-zero and signed overflow when 1.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on the rising edge.
REQ-004 reset  input  1  SHALL be an asynchronous, active-high reset.
REQ-005 valid_i  input  1  SHALL mark a valid operation request.
REQ-006 ready_o  output  1  SHALL be high when a request can be accepted.
REQ-007 funct3_i  input  3  SHALL carry the RV32M operation: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-008 rs1_i  input  DWIDTH  SHALL carry operand A (multiplicand or dividend).
REQ-009 rs2_i  input  DWIDTH  SHALL carry operand B (multiplier or divisor).
REQ-010 kill_i  input  1  SHALL carry the pipeline flush that aborts any in-flight operation.
REQ-011 valid_o  output  1  SHALL mark res_o valid.
REQ-012 ready_i  input  1  SHALL mark the consumer as accepting the result.
REQ-013 res_o  output  DWIDTH  SHALL carry the operation result.

Function
REQ-014 States SHALL be IDLE, BUSY and DONE.
REQ-015 ready_o SHALL equal (state == IDLE) and SHALL be independent of valid_i.
REQ-016 Accept SHALL occur on an edge with valid_i && ready_o && !kill_i; operands, funct3 and operand sign flags SHALL be latched on that edge.
REQ-017 On accept, the block SHALL enter BUSY with the iteration counter loaded to DWIDTH.
REQ-018 Each BUSY cycle SHALL perform one radix-2 step: shift-add for multiply on magnitudes over a 2*DWIDTH product, restoring shift-subtract for divide on magnitudes.
REQ-019 BUSY SHALL decrement the counter each cycle and move to DONE on the edge where the counter is 1.
REQ-020 Latency: with the accept edge as cycle 0, valid_o SHALL first be high in cycle DWIDTH+1.
REQ-021 Signed operands SHALL be converted to magnitudes at accept.
REQ-022 MUL, MULH and DIV/REM SHALL treat both operands as signed; MULHSU SHALL treat only rs1 as signed; MULHU, DIVU and REMU SHALL treat both as unsigned.
REQ-023 The final sign correction SHALL be applied when entering DONE, and res_o SHALL be a registered value.
REQ-024 MUL SHALL return product[DWIDTH-1:0]; MULH, MULHSU and MULHU SHALL return product[2*DWIDTH-1:DWIDTH].
REQ-025 Quotient sign SHALL be sign(A) xor sign(B); remainder sign SHALL follow the dividend.
REQ-026 Divide by zero SHALL return all-ones for DIV/DIVU and rs1 for REM/REMU.
REQ-027 Signed overflow (A = most-negative, B = -1) SHALL return A for DIV and 0 for REM.
REQ-028 With FAST_SPECIAL=1, the REQ-026/027 cases SHALL go IDLE->DONE, so valid_o is high in cycle 1; with FAST_SPECIAL=0 they SHALL run the full iteration and produce the same result.
REQ-029 DONE SHALL hold valid_o and a stable res_o until ready_i is sampled high, then return to IDLE on that edge.
REQ-030 No new request SHALL be accepted in the cycle a result is retired.
REQ-031 kill_i high on any edge SHALL force IDLE, discard the operation, and prevent valid_o from being asserted for it.
REQ-032 kill_i SHALL take priority over both accept and retire.
REQ-033 Requests presented while ready_o is low SHALL be ignored and SHALL not be queued.

Reset
REQ-034 While reset is high: state IDLE, counter 0, ready_o 1, valid_o 0, res_o 0, all datapath registers 0.
REQ-035 Reset asserted mid-operation SHALL abandon the operation immediately, asynchronously to clk.
REQ-036 After reset deasserts, the first valid_i SHALL be accepted normally.

Verification
REQ-037 MUL 7 x 0xFFFFFFFD, accepted in cycle 0 -> valid_o first high in cycle 33, res_o 0xFFFFFFEB.
REQ-038 MULH 0x80000000 x 0x80000000 -> 0x40000000; MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE.
REQ-039 DIV 0xFFFFFFF9 / 2 -> 0xFFFFFFFD; REM of the same operands -> 0xFFFFFFFF; DIVU 100 / 7 -> 14.
REQ-040 DIVU 5 / 0 -> 0xFFFFFFFF in cycle 1; REMU 5 / 0 -> 5; DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000; REM of the same operands -> 0.
REQ-041 Hold ready_i low 5 cycles after valid_o rises -> valid_o and res_o stable throughout; retire on the first ready_i high; ready_o high the next cycle.
REQ-042 Assert kill_i in cycle 10 of a DIV -> IDLE in cycle 11 and no valid_o. Assert reset in cycle 20 of a MUL -> outputs take reset values immediately, then a fresh MUL 3 x 4 -> 12.
